// File: rtl/c3aibadapt_dprio_pkg.sv
// Shared types and address helpers for the TX DPRIO configuration bank.
// Holds the commit FSM state type, STAT bit positions and CTRL/STAT offsets.
package c3aibadapt_dprio_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } dprio_state_e;

   localparam int STAT_BUSY_BIT = 0;
   localparam int STAT_ERR_BIT  = 1;

   function automatic int ctrl_off(input int nch, input int nreg);
      return nch * nreg;
   endfunction

   function automatic int stat_off(input int nch, input int nreg);
      return nch * nreg + 1;
   endfunction

endpackage

// File: rtl/c3aibadapt_dprio_chbank.sv
// One channel of shadow and active configuration bytes.
// Ports: clk/rst_n, byte write port (wr_en/wr_idx/wr_data), commit copy strobe, flattened outputs.
module c3aibadapt_dprio_chbank
   import c3aibadapt_dprio_pkg::*;
#(
   parameter int NREG = 8,
   parameter int RW   = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [RW-1:0]     wr_idx,
   input  logic [7:0]        wr_data,
   input  logic              commit,
   output logic [NREG*8-1:0] shadow_out,
   output logic [NREG*8-1:0] active_out
);

   logic [7:0] shadow_q [NREG];
   logic [7:0] shadow_d [NREG];
   logic [7:0] active_q [NREG];
   logic [7:0] active_d [NREG];

   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         shadow_d[r] = shadow_q[r];
         active_d[r] = active_q[r];
         if (wr_en && (wr_idx == RW'(r))) shadow_d[r] = wr_data;
         // copy takes the pre-edge shadow value
         if (commit) active_d[r] = shadow_q[r];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            shadow_q[r] <= 8'h00;
            active_q[r] <= 8'h00;
         end
      end else begin
         for (int r = 0; r < NREG; r++) begin
            shadow_q[r] <= shadow_d[r];
            active_q[r] <= active_d[r];
         end
      end
   end

   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         shadow_out[r*8 +: 8] = shadow_q[r];
         active_out[r*8 +: 8] = active_q[r];
      end
   end

endmodule

// File: rtl/c3aibadapt_tx_dprio_bank.sv
// AVMM-programmed TX configuration bank with shadow/active bytes and masked commit.
// Ports: avmm_* slave bus, tx_cfg_out active config, tx_cfg_update per-channel pulse, commit_busy.
module c3aibadapt_tx_dprio_bank
   import c3aibadapt_dprio_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int NREG   = 8,
   parameter int ADDR_W = 8
) (
   input  logic                     avmm_clk,
   input  logic                     avmm_rst_n,
   input  logic                     avmm_write,
   input  logic                     avmm_read,
   input  logic [ADDR_W-1:0]        avmm_address,
   input  logic [7:0]               avmm_writedata,
   output logic [7:0]               avmm_readdata,
   output logic                     avmm_readdatavalid,
   output logic                     avmm_waitrequest,
   output logic [NUM_CH*NREG*8-1:0] tx_cfg_out,
   output logic [NUM_CH-1:0]        tx_cfg_update,
   output logic                     commit_busy
);

   localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(ctrl_off(NUM_CH, NREG));
   localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(stat_off(NUM_CH, NREG));
   localparam logic [CW-1:0]     LAST_I = CW'(NUM_CH - 1);

   dprio_state_e      state_q, state_d;
   logic [CW-1:0]     idx_q, idx_d;
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic [NUM_CH-1:0] upd_q, upd_d;
   logic              rdv_q, rdv_d;
   logic [7:0]        rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [NREG*8-1:0] sh_w  [NUM_CH];
   logic [NREG*8-1:0] act_w [NUM_CH];
   logic [NUM_CH-1:0] wr_ch;
   logic [NUM_CH-1:0] cm;
   logic [NUM_CH-1:0] wr_mask;
   logic [ADDR_W-1:0] ch_sel;
   logic [RW-1:0]     reg_idx;
   logic              busy, acc, acc_wr, acc_rd, is_sh;
   logic [7:0]        rd_sh, stat_v;

   assign busy    = (state_q == SCAN);
   assign acc     = !busy;
   assign acc_wr  = acc && avmm_write;
   // a read alongside a write is dropped
   assign acc_rd  = acc && avmm_read && !avmm_write;
   assign is_sh   = (avmm_address < CTRL_A);
   assign ch_sel  = avmm_address >> RW;
   assign reg_idx = avmm_address[RW-1:0];
   assign wr_mask = avmm_writedata[NUM_CH-1:0];

   always_comb begin
      rd_sh = 8'h00;
      wr_ch = '0;
      cm    = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_sel == ADDR_W'(c)) begin
            rd_sh    = sh_w[c][{reg_idx, 3'b000} +: 8];
            wr_ch[c] = acc_wr && is_sh;
         end
         if (busy && (idx_q == CW'(c)) && mask_q[c]) cm[c] = 1'b1;
      end
   end

   always_comb begin
      stat_v = 8'h00;
      stat_v[STAT_ERR_BIT]  = err_q;
      stat_v[STAT_BUSY_BIT] = busy;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mask_d  = mask_q;
      upd_d   = cm;
      rdv_d   = 1'b0;
      rdata_d = 8'h00;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (acc_wr && (avmm_address == CTRL_A) && (wr_mask != '0)) begin
               state_d = SCAN;
               idx_d   = '0;
               mask_d  = wr_mask;
            end
         end
         SCAN: begin
            if (idx_q == LAST_I) state_d = IDLE;
            else idx_d = idx_q + CW'(1);
         end
         default: ;
      endcase
      if (acc_rd) begin
         rdv_d = 1'b1;
         if (is_sh) rdata_d = rd_sh;
         else if (avmm_address == STAT_A) rdata_d = stat_v;
      end
      if (acc_wr && (avmm_address == STAT_A) && avmm_writedata[STAT_ERR_BIT])
         err_d = 1'b0;
      // set has priority over the clear above
      if ((acc && avmm_write && avmm_read) ||
          (acc && (avmm_write || avmm_read) && (avmm_address > STAT_A)))
         err_d = 1'b1;
   end

   always_ff @(posedge avmm_clk) begin
      if (!avmm_rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         mask_q  <= '0;
         upd_q   <= '0;
         rdv_q   <= 1'b0;
         rdata_q <= 8'h00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         mask_q  <= mask_d;
         upd_q   <= upd_d;
         rdv_q   <= rdv_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      c3aibadapt_dprio_chbank #(
         .NREG(NREG),
         .RW  (RW)
      ) u_chbank (
         .clk       (avmm_clk),
         .rst_n     (avmm_rst_n),
         .wr_en     (wr_ch[c]),
         .wr_idx    (reg_idx),
         .wr_data   (avmm_writedata),
         .commit    (cm[c]),
         .shadow_out(sh_w[c]),
         .active_out(act_w[c])
      );
      assign tx_cfg_out[c*NREG*8 +: NREG*8] = act_w[c];
   end

   assign avmm_readdata      = rdata_q;
   assign avmm_readdatavalid = rdv_q;
   assign avmm_waitrequest   = busy;
   assign commit_busy        = busy;
   assign tx_cfg_update      = upd_q;

endmodule

// File: tb/tb_c3aibadapt_tx_dprio_bank.sv
// Directed self-checking bench for the TX DPRIO configuration bank.
// Default parameters: 4 channels x 8 bytes, CTRL at 0x20, STAT at 0x21.
module tb_c3aibadapt_tx_dprio_bank;

   localparam int NUM_CH = 4;
   localparam int NREG   = 8;
   localparam int ADDR_W = 8;
   localparam int CFGW   = NUM_CH * NREG * 8;
   localparam logic [7:0] CTRL = 8'h20;
   localparam logic [7:0] STAT = 8'h21;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              write, read;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        wdata;
   logic [7:0]        rdata;
   logic              rdv, waitreq, busy;
   logic [CFGW-1:0]   cfg;
   logic [NUM_CH-1:0] upd;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   c3aibadapt_tx_dprio_bank #(
      .NUM_CH(NUM_CH),
      .NREG  (NREG),
      .ADDR_W(ADDR_W)
   ) dut (
      .avmm_clk          (clk),
      .avmm_rst_n        (rst_n),
      .avmm_write        (write),
      .avmm_read         (read),
      .avmm_address      (addr),
      .avmm_writedata    (wdata),
      .avmm_readdata     (rdata),
      .avmm_readdatavalid(rdv),
      .avmm_waitrequest  (waitreq),
      .tx_cfg_out        (cfg),
      .tx_cfg_update     (upd),
      .commit_busy       (busy)
   );

   task automatic check(input string tag, input logic [255:0] got,
                        input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      write = 1'b1;
      addr  = a;
      wdata = d;
      tick();
      write = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d,
                     output logic v);
      read = 1'b1;
      addr = a;
      tick();
      read = 1'b0;
      d = rdata;
      v = rdv;
   endtask

   logic [7:0]        d;
   logic              v;
   logic [CFGW-1:0]   exp_cfg;
   logic [NUM_CH-1:0] upd_or;
   int                cnt, ucnt, hold_bad;

   initial begin
      rst_n = 1'b0;
      write = 1'b0;
      read  = 1'b0;
      addr  = '0;
      wdata = '0;
      exp_cfg = '0;
      repeat (3) tick();
      check("rst_rdata", rdata, 0);
      check("rst_rdv", rdv, 0);
      check("rst_wait", waitreq, 0);
      check("rst_busy", busy, 0);
      check("rst_upd", upd, 0);
      check("rst_cfg", cfg, 0);
      rst_n = 1'b1;
      tick();

      // read after reset
      rd(8'h00, d, v);
      check("rd0_valid", v, 1);
      check("rd0_data", d, 8'h00);
      tick();
      check("rdv_idle", rdv, 0);
      check("rdata_idle", rdata, 0);

      // shadow write then single-channel commit
      wr(8'd9, 8'hA5);
      check("shadow_no_active", cfg, 0);
      rd(8'd9, d, v);
      check("rd9_data", d, 8'hA5);
      wr(CTRL, 8'h02);
      cnt = 0; ucnt = 0; upd_or = '0;
      while (waitreq && cnt < 20) begin
         upd_or |= upd;
         if (upd != 0) ucnt++;
         tick();
         cnt++;
      end
      upd_or |= upd;
      if (upd != 0) ucnt++;
      check("c1_wait_cycles", cnt, 4);
      check("c1_byte", cfg[79:72], 8'hA5);
      exp_cfg[79:72] = 8'hA5;
      check("c1_cfg", cfg, exp_cfg);
      check("c1_upd_mask", upd_or, 4'b0010);
      check("c1_upd_count", ucnt, 1);
      tick();
      check("c1_upd_clear", upd, 0);

      // full commit with a read held off during the scan
      wr(8'd0, 8'h11);
      wr(CTRL, 8'h0F);
      check("c2_busy", busy, 1);
      read = 1'b1;
      addr = 8'd0;
      cnt = 0; hold_bad = 0; upd_or = '0;
      while (waitreq && cnt < 20) begin
         if (rdv) hold_bad++;
         upd_or |= upd;
         tick();
         cnt++;
      end
      upd_or |= upd;
      tick();
      read = 1'b0;
      check("c2_wait_cycles", cnt, 4);
      check("c2_no_rdv_busy", hold_bad, 0);
      check("c2_rdv", rdv, 1);
      check("c2_rdata", rdata, 8'h11);
      check("c2_upd_all", upd_or, 4'hF);
      exp_cfg[7:0] = 8'h11;
      check("c2_cfg", cfg, exp_cfg);

      // out-of-range read, status, clear
      rd(8'h30, d, v);
      check("oor_valid", v, 1);
      check("oor_data", d, 8'h00);
      rd(STAT, d, v);
      check("stat_err", d, 8'h02);
      wr(STAT, 8'h02);
      rd(STAT, d, v);
      check("stat_clr", d, 8'h00);

      // CTRL reads zero; zero mask after truncation is a no-op
      rd(CTRL, d, v);
      check("ctrl_rd", d, 8'h00);
      wr(CTRL, 8'hF0);
      check("zero_mask_wait", waitreq, 0);
      check("zero_mask_cfg", cfg, exp_cfg);

      // simultaneous write and read
      write = 1'b1;
      read  = 1'b1;
      addr  = 8'd5;
      wdata = 8'h3C;
      tick();
      write = 1'b0;
      read  = 1'b0;
      check("wr_rd_no_rdv", rdv, 0);
      rd(8'd5, d, v);
      check("wr_rd_shadow", d, 8'h3C);
      rd(STAT, d, v);
      check("wr_rd_err", d, 8'h02);

      // clear and set in the same cycle: set wins
      write = 1'b1;
      read  = 1'b1;
      addr  = STAT;
      wdata = 8'h02;
      tick();
      write = 1'b0;
      read  = 1'b0;
      rd(STAT, d, v);
      check("set_wins", d, 8'h02);

      // reset in the third scan cycle
      wr(CTRL, 8'h0F);
      tick();
      tick();
      check("abort_busy_pre", busy, 1);
      rst_n = 1'b0;
      tick();
      check("abort_cfg", cfg, 0);
      check("abort_busy", busy, 0);
      check("abort_wait", waitreq, 0);
      check("abort_upd", upd, 0);
      rst_n = 1'b1;
      tick();
      rd(8'd9, d, v);
      check("abort_shadow", d, 8'h00);
      rd(STAT, d, v);
      check("abort_stat", d, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/c3aibadapt_tx_dprio_bank.md
C3AIBADAPT_TX_DPRIO_BANK -- requirements
Module: c3aibadapt_tx_dprio_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of TX channels; legal range 1..8.
REQ-002 SHALL have parameter NREG, default 8: configuration bytes per channel; legal values are powers of two, 2..32.
REQ-003 SHALL have parameter ADDR_W, default 8: AVMM address width; must satisfy 2^ADDR_W >= NUM_CH*NREG+2.
REQ-004 SHALL have port avmm_clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port avmm_rst_n, input, width 1: reset, synchronous and active-low.
REQ-006 SHALL have port avmm_write, input, width 1: write request.
REQ-007 SHALL have port avmm_read, input, width 1: read request.
REQ-008 SHALL have port avmm_address, input, width ADDR_W: byte address.
REQ-009 SHALL have port avmm_writedata, input, width 8: write data.
REQ-010 SHALL have port avmm_readdata, output, width 8: read data.
REQ-011 SHALL have port avmm_readdatavalid, output, width 1: one-cycle pulse that qualifies avmm_readdata.
REQ-012 SHALL have port avmm_waitrequest, output, width 1: when high, the request is not accepted.
REQ-013 SHALL have port tx_cfg_out, output, width NUM_CH*NREG*8: active configuration; channel c, register r occupies bits [(c*NREG+r)*8 +: 8].
REQ-014 SHALL have port tx_cfg_update, output, width NUM_CH: bit c pulses for one cycle when the active registers of channel c change.
REQ-015 SHALL have port commit_busy, output, width 1: high while a commit sequence is running.

Function
REQ-016 Address map SHALL be: 0..NUM_CH*NREG-1 = shadow byte (c*NREG+r); CTRL = NUM_CH*NREG is the commit mask (write-only, reads return 0x00); STAT = CTRL+1 is status {6'b0, err, busy}.
REQ-017 A write to a shadow address accepted when waitrequest is low SHALL update that shadow byte at the next edge; tx_cfg_out SHALL not change.
REQ-018 A read accepted when waitrequest is low SHALL assert avmm_readdatavalid exactly 1 cycle later; readdata SHALL carry the shadow byte, or STAT, or 0x00.
REQ-019 avmm_readdata SHALL be 0x00 whenever avmm_readdatavalid is low.
REQ-020 A write to CTRL with a nonzero mask M[NUM_CH-1:0] SHALL start a commit; mask bits at or above NUM_CH SHALL be ignored, and a resulting zero mask SHALL be a no-op.
REQ-021 Commit state machine: IDLE -> SCAN on an accepted nonzero CTRL write.
REQ-022 In SCAN, one channel index SHALL be examined per cycle, in ascending order from 0; if its mask bit is set, shadow SHALL be copied to active for all NREG bytes of that channel in that cycle, and tx_cfg_update[c] SHALL pulse on the following cycle.
REQ-023 SCAN -> IDLE after index NUM_CH-1; the sequence SHALL last exactly NUM_CH cycles.
REQ-024 commit_busy and avmm_waitrequest SHALL be high in every cycle the FSM is in SCAN, and low otherwise.
REQ-025 tx_cfg_update[c] SHALL pulse even if the copied data equals the current active value.
REQ-026 An access to an address above STAT SHALL be completed: writes are ignored, reads return 0x00 with readdatavalid, and the err flag is set.
REQ-027 avmm_write and avmm_read asserted together SHALL perform the write only, suppress the read (no readdatavalid), and set err.
REQ-028 Writing STAT with bit1 = 1 SHALL clear err; if err is set by another event in the same cycle, the set SHALL win.
REQ-029 Requests asserted while waitrequest is high SHALL have no effect and SHALL be held by the master until accepted.

Reset
REQ-030 While avmm_rst_n = 0 at a clock edge: all shadow and active bytes SHALL be 0x00, FSM = IDLE, err = 0, and avmm_readdata, avmm_readdatavalid, avmm_waitrequest, tx_cfg_update and commit_busy SHALL all be 0.
REQ-031 Reset during SCAN SHALL abort the commit; active values SHALL return to 0x00, including channels already copied in that sequence.

Structure
REQ-032 Package c3aibadapt_dprio_pkg SHALL hold the FSM state type (IDLE, SCAN), the STAT bit positions, and the CTRL/STAT offset functions of NUM_CH and NREG.
REQ-033 Sub-module c3aibadapt_dprio_chbank SHALL be instantiated once per channel; it holds NREG shadow and NREG active bytes, with a write port and a commit-copy strobe.

Verification
REQ-034 Scenario: after reset, read address 0 -> readdatavalid 1 cycle later with readdata 0x00; tx_cfg_out all zero.
REQ-035 Scenario: write 0xA5 to address 9 (ch1, r1), then CTRL = 0x02 -> waitrequest high 4 cycles; tx_cfg_out bits[79:72] = 0xA5; only tx_cfg_update[1] pulses.
REQ-036 Scenario: CTRL = 0x0F, then a read to 0 issued during SCAN -> read held; readdatavalid appears only after busy drops.
REQ-037 Scenario: read address 0x30 -> readdata 0x00; then STAT read returns 0x02; write STAT = 0x02, then read STAT returns 0x00.
REQ-038 Scenario: simultaneous write 0x3C and read on address 5 -> shadow[5] = 0x3C, no readdatavalid, err set.
REQ-039 Scenario: CTRL = 0x0F with reset asserted on the 3rd SCAN cycle -> tx_cfg_out all zero and busy low after reset.
